// File: rtl/shift_exec_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift_exec_stage_pkg
// Description : Shared constants for the R-type shift execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
package shift_exec_stage_pkg;

    localparam int SHIFT_DATA_WIDTH = 32;

    localparam logic [5:0] FUNCT_SLL  = 6'h00;
    localparam logic [5:0] FUNCT_SRL  = 6'h02;
    localparam logic [5:0] FUNCT_SRA  = 6'h03;
    localparam logic [5:0] FUNCT_SLLV = 6'h04;
    localparam logic [5:0] FUNCT_SRLV = 6'h06;
    localparam logic [5:0] FUNCT_SRAV = 6'h07;

    localparam logic [1:0] SHIFT_SLL = 2'b00;
    localparam logic [1:0] SHIFT_SRL = 2'b10;
    localparam logic [1:0] SHIFT_SRA = 2'b11;

    // Shift encodings occupy funct 0x00-0x07 except the unused x1 slots.
    function automatic logic funct_is_shift(input logic [5:0] funct);
        return (funct[5:3] == 3'b000) && (funct[1:0] != 2'b01);
    endfunction

endpackage
`default_nettype wire

// File: rtl/shift_exec_stage_shifter.sv
`default_nettype none
// ============================================================================
// Module      : shift_exec_stage_shifter
// Description : Combinational barrel shifter (left/right logical, right arith).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_exec_stage_shifter
    import shift_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = SHIFT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] i_a,
    input  logic [4:0]            i_b,
    input  logic [1:0]            i_shiftop,
    output logic [DATA_WIDTH-1:0] o_y
);

    always_comb begin
        o_y = i_a;
        case (i_shiftop)
            SHIFT_SLL: o_y = i_a << i_b;
            SHIFT_SRL: o_y = i_a >> i_b;
            SHIFT_SRA: o_y = $unsigned($signed(i_a) >>> i_b);
            default:   o_y = i_a;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/shift_exec_stage.sv
`default_nettype none
// ============================================================================
// Module      : shift_exec_stage
// Description : Two-stage pipelined execute unit for R-type shift instructions.
// Revision    : 1.0 - initial release
// ============================================================================
module shift_exec_stage
    import shift_exec_stage_pkg::*;
#(
    parameter int DATA_WIDTH = SHIFT_DATA_WIDTH,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [5:0]            in_funct,
    input  logic [4:0]            in_shamt,
    input  logic [DATA_WIDTH-1:0] in_rs,
    input  logic [DATA_WIDTH-1:0] in_rt,
    input  logic [REG_ADDR_W-1:0] in_rd,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_result,
    output logic [REG_ADDR_W-1:0] out_rd,
    output logic                  out_illegal
);

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_value;
    logic [4:0]            r_s1_amount;
    logic [1:0]            r_s1_shiftop;
    logic [REG_ADDR_W-1:0] r_s1_rd;
    logic                  r_s1_illegal;

    logic                  r_s2_valid;
    logic [DATA_WIDTH-1:0] r_s2_result;
    logic [REG_ADDR_W-1:0] r_s2_rd;
    logic                  r_s2_illegal;

    logic                  w_s2_advance;
    logic                  w_s1_advance;
    logic                  w_accept;
    logic [4:0]            w_amount;
    logic [DATA_WIDTH-1:0] w_shift_y;
    logic                  w_unused_rs_hi;

    assign w_s2_advance   = !r_s2_valid || out_ready;
    assign w_s1_advance   = r_s1_valid && w_s2_advance;
    assign in_ready       = (!r_s1_valid || w_s2_advance) && !flush;
    assign w_accept       = in_valid && in_ready;
    assign w_amount       = in_funct[2] ? in_rs[4:0] : in_shamt;
    assign w_unused_rs_hi = ^in_rs[DATA_WIDTH-1:5];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
            r_s2_valid <= 1'b0;
        end else begin
            if (w_s2_advance) begin
                r_s2_valid <= r_s1_valid;
            end
            // Flush is low here, so in_ready reflects a free stage-1 slot.
            if (in_ready) begin
                r_s1_valid <= in_valid;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_value   <= in_rt;
            r_s1_amount  <= w_amount;
            r_s1_shiftop <= in_funct[1:0];
            r_s1_rd      <= in_rd;
            r_s1_illegal <= !funct_is_shift(in_funct);
        end
    end

    shift_exec_stage_shifter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shifter (
        .i_a       (r_s1_value),
        .i_b       (r_s1_amount),
        .i_shiftop (r_s1_shiftop),
        .o_y       (w_shift_y)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_result  <= '0;
            r_s2_rd      <= '0;
            r_s2_illegal <= 1'b0;
        end else if (w_s1_advance && !flush) begin
            r_s2_result  <= r_s1_illegal ? '0 : w_shift_y;
            r_s2_rd      <= r_s1_rd;
            r_s2_illegal <= r_s1_illegal;
        end
    end

    assign out_valid   = r_s2_valid;
    assign out_result  = r_s2_result;
    assign out_rd      = r_s2_rd;
    assign out_illegal = r_s2_illegal;

endmodule
`default_nettype wire
